bp_wormhole_to_burst: RTL and testbench

- Receive stage paired with the burst-to-wormhole sender. Consumes wormhole flits from a router or concentrator link.
- Reassembles the full header (wormhole + protocol header) and the protocol data beats, then presents them on BedRock Burst header and data channels (ready&valid).
- Handles one packet at a time.
- Used at network egress for memory/DMA endpoints.

---
 rtl/bp_wormhole_to_burst.sv | 170 +++++++++++++++++
 tb/tb_bp_wormhole_to_burst.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_wormhole_to_burst.sv
// Wormhole flit stream to BedRock Burst header/data reassembly (one packet at a time).
// Optional length checking is enabled by defining BP_WORMHOLE_TO_BURST_LEN_CHECK_EN.
module bp_wormhole_to_burst #(
    parameter int flit_width_p    = 32,
    parameter int cord_width_p    = 4,
    parameter int len_width_p     = 4,
    parameter int cid_width_p     = 0,
    parameter int pr_hdr_width_p  = 56,
    parameter int pr_data_width_p = 64,
    parameter int hdr_width_p     = cord_width_p + len_width_p
                                  + cid_width_p + pr_hdr_width_p
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [flit_width_p-1:0]    link_data_i,
    input  logic                       link_v_i,
    output logic                       link_ready_and_o,
    output logic [hdr_width_p-1:0]     hdr_o,
    output logic                       hdr_v_o,
    input  logic                       hdr_ready_and_i,
    output logic [pr_data_width_p-1:0] data_o,
    output logic                       data_v_o,
    input  logic                       data_ready_and_i,
    output logic                       last_o,
    output logic                       err_o
);

    localparam int hdr_len_lp  = hdr_width_p / flit_width_p;
    localparam int data_len_lp = pr_data_width_p / flit_width_p;
    localparam int hcnt_w_lp   = $clog2(hdr_len_lp + 1);
    localparam int dcnt_w_lp   = $clog2(data_len_lp + 1);
    localparam logic [len_width_p:0] hdr_m1_lp = (len_width_p+1)'(hdr_len_lp - 1);

    typedef enum logic [1:0] {
        e_hdr_in,
        e_hdr_out,
        e_data
    } state_e;

    state_e                     r_state, w_state_n;
    logic [hdr_width_p-1:0]     r_hdr, w_hdr_n;
    logic [hcnt_w_lp-1:0]       r_hcnt;
    logic [len_width_p-1:0]     r_rem, w_cnt, w_len;
    logic [len_width_p:0]       w_len_x;
    logic [pr_data_width_p-1:0] r_data;
    logic [dcnt_w_lp-1:0]       r_slot, w_slot;
    logic                       r_full, r_last;
    logic                       w_acc, w_drain, w_hdr_last;

    assign hdr_o   = r_hdr;
    assign data_o  = r_data;
    assign w_acc   = link_v_i & link_ready_and_o;
    assign w_drain = data_v_o & data_ready_and_i;
    assign w_slot  = w_drain ? '0 : r_slot;
    assign w_hdr_last = (r_hcnt == hcnt_w_lp'(hdr_len_lp - 1));

    // Header image including the flit arriving now; len is read from it.
    always_comb begin
        w_hdr_n = r_hdr;
        w_hdr_n[int'(r_hcnt)*flit_width_p +: flit_width_p] = link_data_i;
    end

    assign w_len   = w_hdr_n[cord_width_p +: len_width_p];
    assign w_len_x = {1'b0, w_len};
    assign w_cnt   = (w_len_x < hdr_m1_lp) ? '0
                   : len_width_p'(w_len_x - hdr_m1_lp);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= e_hdr_in;
        else         r_state <= w_state_n;
    end

    always_comb begin
        w_state_n        = r_state;
        link_ready_and_o = 1'b0;
        hdr_v_o          = 1'b0;
        data_v_o         = 1'b0;
        last_o           = 1'b0;
        unique case (r_state)
            e_hdr_in: begin
                link_ready_and_o = 1'b1;
                if (link_v_i && w_hdr_last) w_state_n = e_hdr_out;
            end
            e_hdr_out: begin
                hdr_v_o = 1'b1;
                if (hdr_ready_and_i)
                    w_state_n = (r_rem != '0) ? e_data : e_hdr_in;
            end
            e_data: begin
                data_v_o = r_full;
                last_o   = r_full & r_last;
                link_ready_and_o = (r_rem != '0) & (~r_full | data_ready_and_i);
                if (r_full && r_last && data_ready_and_i) w_state_n = e_hdr_in;
            end
            default: w_state_n = e_hdr_in;
        endcase
        if (reset_i) link_ready_and_o = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_hdr  <= '0;
            r_hcnt <= '0;
            r_rem  <= '0;
            r_data <= '0;
            r_slot <= '0;
            r_full <= 1'b0;
            r_last <= 1'b0;
        end else begin
            unique case (r_state)
                e_hdr_in: begin
                    if (w_acc) begin
                        r_hdr <= w_hdr_n;
                        if (w_hdr_last) begin
                            r_hcnt <= '0;
                            r_rem  <= w_cnt;
                        end else begin
                            r_hcnt <= r_hcnt + 1'b1;
                        end
                    end
                end
                e_hdr_out: begin
                    if (hdr_ready_and_i) begin
                        r_slot <= '0;
                        r_full <= 1'b0;
                        r_last <= 1'b0;
                    end
                end
                e_data: begin
                    // Slot 0 write clears the beat so a short final beat is zero-padded.
                    if (w_acc) begin
                        if (w_slot == '0)
                            r_data <= pr_data_width_p'(link_data_i);
                        else
                            r_data[int'(w_slot)*flit_width_p +: flit_width_p] <= link_data_i;
                        r_slot <= w_slot + 1'b1;
                        r_rem  <= r_rem - 1'b1;
                        r_full <= (w_slot + 1'b1 == dcnt_w_lp'(data_len_lp))
                                | (r_rem == len_width_p'(1));
                        r_last <= (r_rem == len_width_p'(1));
                    end else if (w_drain) begin
                        r_full <= 1'b0;
                        r_slot <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BP_WORMHOLE_TO_BURST_LEN_CHECK_EN
    logic r_err;
    logic w_err;

    assign w_err = (w_len_x < hdr_m1_lp)
                 | ((32'(w_cnt) % data_len_lp) != 0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            r_err <= 1'b0;
        else if (r_state == e_hdr_in && w_acc && w_hdr_last && w_err)
            r_err <= 1'b1;
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_wormhole_to_burst.sv
// Randomized bench for bp_wormhole_to_burst against a packet-level queue model.
module tb_bp_wormhole_to_burst;

    localparam int FW = 32;
    localparam int CW = 4;
    localparam int LW = 4;
    localparam int HL = 2;
    localparam int DL = 2;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [31:0]   link_data_i;
    logic          link_v_i;
    logic          link_ready_and_o;
    logic [63:0]   hdr_o;
    logic          hdr_v_o;
    logic          hdr_ready_and_i;
    logic [63:0]   data_o;
    logic          data_v_o;
    logic          data_ready_and_i;
    logic          last_o;
    logic          err_o;

    bp_wormhole_to_burst #(
        .flit_width_p    (32),
        .cord_width_p    (4),
        .len_width_p     (4),
        .cid_width_p     (0),
        .pr_hdr_width_p  (56),
        .pr_data_width_p (64)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .link_data_i      (link_data_i),
        .link_v_i         (link_v_i),
        .link_ready_and_o (link_ready_and_o),
        .hdr_o            (hdr_o),
        .hdr_v_o          (hdr_v_o),
        .hdr_ready_and_i  (hdr_ready_and_i),
        .data_o           (data_o),
        .data_v_o         (data_v_o),
        .data_ready_and_i (data_ready_and_i),
        .last_o           (last_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] q_flit[$];
    int          q_kind[$];
    logic [63:0] q_hdr[$];
    logic        q_herr[$];
    logic [63:0] q_beat[$];
    logic        q_last[$];
    int          q_bpid[$];

    int pid_gen  = 0;
    int hdr_seen = 0;
    bit m_err    = 0;
    int vmode = 0, hmode = 0, dmode = 0;
    bit b2b = 0;
    bit popped = 0;
    bit hold = 0;
    int cyc = 0;
    int last_dcyc = 0;

    // Packet-level model: split header into flits, group data flits into beats.
    task automatic add_pkt(input logic [63:0] hdr, input bit seq);
        logic [LW-1:0] len;
        int nd;
        bit bad;
        logic [63:0] beat;
        logic [31:0] f;
        len = hdr[CW +: LW];
        nd  = (int'(len) < HL - 1) ? 0 : int'(len) - (HL - 1);
`ifdef BP_WORMHOLE_TO_BURST_LEN_CHECK_EN
        bad = (int'(len) < HL - 1) || (nd % DL != 0);
`else
        bad = 1'b0;
`endif
        m_err = m_err | bad;
        q_flit.push_back(hdr[31:0]);  q_kind.push_back(0);
        q_flit.push_back(hdr[63:32]); q_kind.push_back(0);
        q_hdr.push_back(hdr);
        q_herr.push_back(m_err);
        beat = '0;
        for (int j = 0; j < nd; j++) begin
            f = seq ? 32'(j + 1) : $urandom();
            q_flit.push_back(f);
            q_kind.push_back(j == 0 ? 1 : 2);
            beat[(j % DL)*FW +: FW] = f;
            if ((j % DL == DL - 1) || (j == nd - 1)) begin
                q_beat.push_back(beat);
                q_last.push_back(j == nd - 1);
                q_bpid.push_back(pid_gen);
                beat = '0;
            end
        end
        pid_gen++;
    endtask

    task automatic rand_pkt(input int len);
        logic [63:0] h;
        h = {$urandom(), $urandom()};
        h[CW +: LW] = LW'(len);
        add_pkt(h, 1'b0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q_flit.size() + q_hdr.size() + q_beat.size()) != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        repeat (3) @(negedge clk_i);
        chk("timeout", 32'(q_flit.size() + q_hdr.size() + q_beat.size()), 0);
    endtask

    task automatic flush();
        q_flit.delete(); q_kind.delete();
        q_hdr.delete();  q_herr.delete();
        q_beat.delete(); q_last.delete(); q_bpid.delete();
        m_err = 0;
        hdr_seen = pid_gen;
    endtask

    // Input driver: link valid holds until accepted.
    initial begin
        forever begin
            @(posedge clk_i); #1;
            hold = link_v_i && !popped;
            popped = 0;
            if (q_flit.size() == 0) hold = 0;
            link_v_i = (q_flit.size() != 0)
                     && (hold || vmode == 0 || $urandom_range(0, 3) != 0);
            link_data_i = (q_flit.size() != 0) ? q_flit[0] : '0;
            hdr_ready_and_i  = (hmode == 0) ? 1'b1
                             : (hmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            data_ready_and_i = (dmode == 0) ? 1'b1
                             : (dmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: handshakes sampled on the falling edge.
    logic        p_hv = 0, p_hhs = 0, p_dv = 0, p_dhs = 0, p_last = 0;
    logic [63:0] p_h = 0, p_d = 0;
    initial begin
        int kind;
        int pid;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (reset_i) begin
                p_hv = 0; p_dv = 0;
            end else begin
                if (link_v_i && link_ready_and_o && q_flit.size() != 0) begin
                    void'(q_flit.pop_front());
                    kind = q_kind.pop_front();
                    popped = 1;
                    if (b2b && kind == 2) chk("b2b_rate", 32'(cyc - last_dcyc), 1);
                    if (kind >= 1) last_dcyc = cyc;
                end
                if (hdr_v_o) chk("hdr_stall", link_ready_and_o, 0);
                if (p_hv && !p_hhs) chk("hdr_hold", {hdr_v_o, hdr_o}, {1'b1, p_h});
                if (p_dv && !p_dhs)
                    chk("data_hold", {data_v_o, last_o, data_o}, {1'b1, p_last, p_d});
                if (hdr_v_o && hdr_ready_and_i) begin
                    if (q_hdr.size() == 0) chk("hdr_extra", hdr_v_o, 0);
                    else begin
                        chk("hdr", hdr_o, q_hdr.pop_front());
                        chk("hdr_err", err_o, q_herr.pop_front());
                        hdr_seen++;
                    end
                end
                if (data_v_o && data_ready_and_i) begin
                    if (q_beat.size() == 0) chk("data_extra", data_v_o, 0);
                    else begin
                        pid = q_bpid.pop_front();
                        chk("order", pid < hdr_seen, 1);
                        chk("beat", data_o, q_beat.pop_front());
                        chk("last", last_o, q_last.pop_front());
                    end
                end
                p_hv = hdr_v_o;  p_hhs = hdr_ready_and_i;  p_h = hdr_o;
                p_dv = data_v_o; p_dhs = data_ready_and_i; p_d = data_o;
                p_last = last_o;
            end
        end
    end

    initial begin
        int n;
        reset_i = 0;
        link_v_i = 0;
        link_data_i = '0;
        hdr_ready_and_i = 1;
        data_ready_and_i = 1;
        #2 reset_i = 1;
        #1 chk("reset_out",
               {hdr_v_o, data_v_o, last_o, err_o, link_ready_and_o}, 5'b0);
        repeat (3) @(negedge clk_i);
        chk("reset_hold",
            {hdr_v_o, data_v_o, last_o, err_o, link_ready_and_o}, 5'b0);
        #3 reset_i = 0;

        add_pkt({32'hAAAABBBB, 32'h00000054}, 1'b1);
        drain(100);

        add_pkt({32'h12345678, 32'h00000014}, 1'b0);
        drain(100);
        chk("idle_rdy", link_ready_and_o, 1);

        hmode = 2; dmode = 2;
        rand_pkt(5);
        n = 0;
        while (!hdr_v_o && n < 50) begin @(negedge clk_i); n++; end
        chk("wait_hv", hdr_v_o, 1);
        repeat (5) begin
            @(negedge clk_i);
            chk("bp_hdr_rdy", link_ready_and_o, 0);
        end
        hmode = 0;
        n = 0;
        while (!data_v_o && n < 50) begin @(negedge clk_i); n++; end
        chk("wait_dv", data_v_o, 1);
        repeat (5) begin
            @(negedge clk_i);
            chk("bp_data_rdy", {data_v_o, link_ready_and_o}, 2'b10);
        end
        dmode = 0;
        drain(100);

        b2b = 1;
        repeat (3) rand_pkt(5);
        drain(200);
        b2b = 0;

        rand_pkt(7);
        n = 0;
        while (!data_v_o && n < 100) begin @(negedge clk_i); n++; end
        chk("wait_dv2", data_v_o, 1);
        #3 reset_i = 1;
        #1 chk("async_rst",
               {hdr_v_o, data_v_o, last_o, err_o, link_ready_and_o}, 5'b0);
        @(posedge clk_i);
        flush();
        @(negedge clk_i);
        #3 reset_i = 0;
        rand_pkt(5);
        drain(100);

        vmode = 1; hmode = 1; dmode = 1;
        repeat (40) begin
`ifdef BP_WORMHOLE_TO_BURST_LEN_CHECK_EN
            rand_pkt($urandom_range(0, 15));
`else
            rand_pkt(1 + 2 * $urandom_range(0, 7));
`endif
        end
        drain(6000);
        vmode = 0; hmode = 0; dmode = 0;

`ifdef BP_WORMHOLE_TO_BURST_LEN_CHECK_EN
        reset_i = 1;
        @(posedge clk_i);
        flush();
        @(negedge clk_i);
        #3 reset_i = 0;
        add_pkt({32'hCAFEF00D, 32'h00000043}, 1'b1);
        drain(100);
        chk("err_sticky", err_o, 1);
        rand_pkt(5);
        drain(100);
        chk("err_sticky2", err_o, 1);
`else
        chk("err_tied", err_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
